// File: rtl/if_id_pkg.sv
// Shared types for the IF/ID skid register: occupancy state and fetch bundle.
// Bundle geometry follows the default LANES/INST_W/PC_W configuration.
package if_id_pkg;

    localparam int PKG_LANES  = 4;
    localparam int PKG_INST_W = 16;
    localparam int PKG_PC_W   = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [PKG_LANES*PKG_PC_W-1:0]   pc;
        logic [PKG_LANES*PKG_INST_W-1:0] inst;
        logic [PKG_LANES*PKG_PC_W-1:0]   recv_pc;
        logic [PKG_LANES-1:0]            pred;
        logic [PKG_LANES-1:0]            lane_mask;
    } bundle_t;

endpackage

// File: rtl/if_id_entry.sv
// Load-enabled, clearable fetch-bundle register (main or skid slot).
// Clear wins over load so a flush always empties the slot.
module if_id_entry
    import if_id_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load,
    input  logic    clear,
    input  bundle_t d,
    output bundle_t q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_skid_reg.sv
// Two-entry IF/ID skid register with registered in_rdy and flush.
// Define IF_ID_STALL_CNT_EN to add the saturating stall_cnt output.
module if_id_skid_reg
    import if_id_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int INST_W = 16,
    parameter int PC_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [LANES*PC_W-1:0]   pc_in,
    input  logic [LANES*INST_W-1:0] inst_in,
    input  logic [LANES*PC_W-1:0]   recv_pc_in,
    input  logic [LANES-1:0]        pred_in,
    input  logic [LANES-1:0]        lane_mask_in,
    input  logic                    flush,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [LANES*PC_W-1:0]   pc_out,
    output logic [LANES*INST_W-1:0] inst_out,
    output logic [LANES*PC_W-1:0]   recv_pc_out,
    output logic [LANES-1:0]        pred_out,
    output logic [LANES-1:0]        lane_mask_out
`ifdef IF_ID_STALL_CNT_EN
    ,
    output logic [15:0]             stall_cnt
`endif
);

    state_t  state;
    state_t  nxt;
    bundle_t in_b;
    bundle_t main_d;
    bundle_t main_q;
    bundle_t skid_q;
    logic    main_ld;
    logic    main_clr;
    logic    skid_ld;
    logic    skid_clr;
    logic    rdy_q;
    logic    xin;
    logic    xout;

    assign in_b = '{
        pc:        pc_in,
        inst:      inst_in,
        recv_pc:   recv_pc_in,
        pred:      pred_in,
        lane_mask: lane_mask_in
    };

    assign out_vld = (state != EMPTY);
    assign in_rdy  = rdy_q;
    assign xin     = in_vld && rdy_q;
    assign xout    = out_vld && out_rdy;

    always_comb begin
        nxt      = state;
        main_d   = in_b;
        main_ld  = 1'b0;
        main_clr = 1'b0;
        skid_ld  = 1'b0;
        skid_clr = 1'b0;
        if (flush) begin
            nxt      = EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (xin) begin
                        nxt     = ONE;
                        main_ld = 1'b1;
                    end
                end
                ONE: begin
                    if (xin && xout) begin
                        main_ld = 1'b1;
                    end else if (xin) begin
                        nxt     = FULL;
                        skid_ld = 1'b1;
                    end else if (xout) begin
                        nxt      = EMPTY;
                        main_clr = 1'b1;
                    end
                end
                FULL: begin
                    if (xout) begin
                        nxt      = ONE;
                        main_d   = skid_q;
                        main_ld  = 1'b1;
                        skid_clr = 1'b1;
                    end
                end
                default: begin
                    nxt      = EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    // in_rdy is the registered "skid will be empty" so out_rdy never reaches it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            rdy_q <= 1'b1;
        end else begin
            state <= nxt;
            rdy_q <= (nxt != FULL);
        end
    end

    if_id_entry u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_ld),
        .clear (main_clr),
        .d     (main_d),
        .q     (main_q)
    );

    if_id_entry u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_ld),
        .clear (skid_clr),
        .d     (in_b),
        .q     (skid_q)
    );

    assign pc_out        = main_q.pc;
    assign inst_out      = main_q.inst;
    assign recv_pc_out   = main_q.recv_pc;
    assign pred_out      = main_q.pred;
    assign lane_mask_out = out_vld ? main_q.lane_mask : '0;

`ifdef IF_ID_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_vld && !out_rdy && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Scoreboard bench for if_id_skid_reg: directed handshake cases plus
// randomised traffic with flushes.
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_vld = 1'b0;
    logic        in_rdy;
    logic [63:0] pc_in = '0;
    logic [63:0] inst_in = '0;
    logic [63:0] recv_pc_in = '0;
    logic [3:0]  pred_in = '0;
    logic [3:0]  lane_mask_in = '0;
    logic        flush = 1'b0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [63:0] pc_out;
    logic [63:0] inst_out;
    logic [63:0] recv_pc_out;
    logic [3:0]  pred_out;
    logic [3:0]  lane_mask_out;
`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] inst;
        logic [63:0] recv;
        logic [3:0]  pred;
        logic [3:0]  mask;
    } item_t;

    item_t q[$];
    int    total = 0;
    int    bad = 0;
    int    pops = 0;

    always #5 clk = ~clk;

    if_id_skid_reg dut (
        .clk           (clk),
        .rst           (rst),
        .in_vld        (in_vld),
        .in_rdy        (in_rdy),
        .pc_in         (pc_in),
        .inst_in       (inst_in),
        .recv_pc_in    (recv_pc_in),
        .pred_in       (pred_in),
        .lane_mask_in  (lane_mask_in),
        .flush         (flush),
        .out_vld       (out_vld),
        .out_rdy       (out_rdy),
        .pc_out        (pc_out),
        .inst_out      (inst_out),
        .recv_pc_out   (recv_pc_out),
        .pred_out      (pred_out),
        .lane_mask_out (lane_mask_out)
`ifdef IF_ID_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] pc);
        in_vld       = v;
        pc_in        = pc;
        inst_in      = {$urandom, $urandom};
        recv_pc_in   = {$urandom, $urandom};
        pred_in      = 4'($urandom);
        lane_mask_in = 4'($urandom);
    endtask

    // Book-keep the handshakes that the coming edge will perform, then step.
    task automatic cyc();
        item_t       e;
        logic        stalled;
        logic [63:0] held_pc;
        logic [3:0]  held_mask;
        stalled   = out_vld && !out_rdy && !flush;
        held_pc   = pc_out;
        held_mask = lane_mask_out;
        if (flush) begin
            q.delete();
        end else begin
            if (out_vld && out_rdy) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    pops++;
                    chk("pc", pc_out, e.pc);
                    chk("inst", inst_out, e.inst);
                    chk("recv_pc", recv_pc_out, e.recv);
                    chk("pred", 64'(pred_out), 64'(e.pred));
                    chk("mask", 64'(lane_mask_out), 64'(e.mask));
                end
            end
            if (in_vld && in_rdy)
                q.push_back('{pc_in, inst_in, recv_pc_in, pred_in, lane_mask_in});
        end
        @(posedge clk);
        #1;
        if (stalled) begin
            chk("hold_pc", pc_out, held_pc);
            chk("hold_mask", 64'(lane_mask_out), 64'(held_mask));
        end
    endtask

    task automatic drain();
        in_vld  = 1'b0;
        flush   = 1'b0;
        out_rdy = 1'b1;
        for (int i = 0; i < 6 && q.size() != 0; i++) cyc();
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("drain_vld", 64'(out_vld), 64'd0);
    endtask

    initial begin
        int base;
        #1 rst = 1'b1;
        #1;
        chk("rst_vld", 64'(out_vld), 64'd0);
        chk("rst_rdy", 64'(in_rdy), 64'd1);
        chk("rst_mask", 64'(lane_mask_out), 64'd0);
        chk("rst_pc", pc_out, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // stall counter / hold: one bundle stuck for five cycles
        out_rdy = 1'b0;
        drive(1'b1, 64'h0000_0000_0000_0100);
        cyc();
        in_vld = 1'b0;
        for (int i = 0; i < 5; i++) cyc();
`ifdef IF_ID_STALL_CNT_EN
        chk("stall_cnt", 64'(stall_cnt), 64'd5);
`endif
        chk("stall_vld", 64'(out_vld), 64'd1);
        drain();

        // single pass-through with one-cycle latency
        out_rdy = 1'b1;
        drive(1'b1, 64'h0010_000C_0008_0004);
        cyc();
        in_vld = 1'b0;
        chk("pass_vld", 64'(out_vld), 64'd1);
        chk("pass_pc", pc_out, 64'h0010_000C_0008_0004);
        drain();

        // back-pressure: A then B fill both entries
        out_rdy = 1'b0;
        drive(1'b1, 64'hAAAA);
        cyc();
        drive(1'b1, 64'hBBBB);
        cyc();
        in_vld = 1'b0;
        chk("bp_rdy", 64'(in_rdy), 64'd0);
        chk("bp_pc_a", pc_out, 64'hAAAA);
        drive(1'b1, 64'hCCCC);
        cyc();
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        cyc();
        chk("bp_pc_b", pc_out, 64'hBBBB);
        chk("bp_rdy2", 64'(in_rdy), 64'd1);
        drain();

        // flush while FULL with a bundle presented at the same time
        out_rdy = 1'b0;
        drive(1'b1, 64'h1111);
        cyc();
        drive(1'b1, 64'h2222);
        cyc();
        drive(1'b1, 64'hEEEE);
        flush = 1'b1;
        cyc();
        flush  = 1'b0;
        in_vld = 1'b0;
        chk("fl_vld", 64'(out_vld), 64'd0);
        chk("fl_rdy", 64'(in_rdy), 64'd1);
        chk("fl_mask", 64'(lane_mask_out), 64'd0);
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("fl_leak", 64'(out_vld), 64'd0);
        end

        // streaming: 20 bundles, one per cycle, never FULL
        base    = pops;
        out_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 64'(32'h4000 + i));
            if (i % 5 == 0) lane_mask_in = 4'd0;
            cyc();
            chk("st_rdy", 64'(in_rdy), 64'd1);
            chk("st_vld", 64'(out_vld), 64'd1);
        end
        in_vld = 1'b0;
        cyc();
        chk("st_count", 64'(pops - base), 64'd20);
        drain();

        // reset while FULL clears outputs before the next edge
        out_rdy = 1'b0;
        drive(1'b1, 64'h5555);
        lane_mask_in = 4'hF;
        cyc();
        drive(1'b1, 64'h6666);
        cyc();
        in_vld = 1'b0;
        chk("mr_full", 64'(in_rdy), 64'd0);
        #2 rst = 1'b1;
        #1;
        chk("mr_vld", 64'(out_vld), 64'd0);
        chk("mr_mask", 64'(lane_mask_out), 64'd0);
        chk("mr_pc", pc_out, 64'd0);
        chk("mr_rdy", 64'(in_rdy), 64'd1);
        q.delete();
        #1 rst = 1'b0;
        out_rdy = 1'b1;
        drive(1'b1, 64'h7777);
        cyc();
        in_vld = 1'b0;
        chk("post_rst_vld", 64'(out_vld), 64'd1);
        chk("post_rst_pc", pc_out, 64'h7777);
        drain();

        // random traffic with occasional flushes
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), 64'(32'h9000 + i));
            out_rdy = 1'($urandom_range(0, 2) != 0);
            flush   = ($urandom_range(0, 29) == 0);
            cyc();
            chk("rnd_vld_mask", 64'(out_vld || lane_mask_out == 4'd0), 64'd1);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
